if_fetch_queue: RTL

Instruction-fetch stage between the PC and the decode stage. It owns the program counter and drives the chip-enable and byte address of the combinational instruction ROM. Each returned instruction is captured, with its PC, into a small FIFO that feeds the ID stage over a valid/ready handshake. Branch and exception redirects reload the PC and discard every fetched but unconsumed instruction.

---
 rtl/if_fetch_queue.sv | 95 +++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and buffers
// fetched {pc, inst} pairs in a small FIFO feeding decode over valid/ready.
module if_fetch_queue #(
    parameter int                DEPTH    = 2,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              redirect;
    logic              full;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] redirect_pc;

    always_comb begin
        redirect    = flush | branch_flag;
        full        = (count == CNT_W'(DEPTH));
        pop         = id_valid & id_ready;
        push        = rom_ce & ~redirect & (~full | pop);
        // Flush outranks branch; targets are forced word-aligned.
        redirect_pc = (flush ? new_pc : branch_target) & ~ADDR_W'(3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_ce <= 1'b0;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rom_ce <= 1'b1;
            if (redirect) begin
                pc     <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + ADDR_W'(4);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Storage is not reset; stale entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pc;
            mem_inst[wr_ptr] <= rom_inst;
        end
    end

    always_comb begin
        rom_addr = rom_ce ? pc : '0;
        id_valid = (count != '0);
        id_pc    = id_valid ? mem_pc[rd_ptr]   : '0;
        id_inst  = id_valid ? mem_inst[rd_ptr] : '0;
    end

endmodule
